// File: rtl/booth_pkg.sv
// Shared constants, Booth selection codes and sequencer states for the
// radix-4 partial-product sender.
package booth_pkg;

    localparam int WIDTH  = 32;
    localparam int PP_NUM = WIDTH / 2 + 1;
    localparam int PROD_W = 2 * WIDTH;
    localparam int EXT_W  = WIDTH + 2;
    localparam int IDX_W  = $clog2(PP_NUM);

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        SEND,
        DONE
    } state_e;

    function automatic booth_sel_e booth_decode(input logic [2:0] trip);
        case (trip)
            3'b001, 3'b010: booth_decode = POS1;
            3'b011:         booth_decode = POS2;
            3'b100:         booth_decode = NEG2;
            3'b101, 3'b110: booth_decode = NEG1;
            default:        booth_decode = ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_sel_row.sv
// Turns one Booth selection and the extended multiplicand into an unshifted
// PROD_W-bit row; negation is a full two's complement, no separate neg bit.
module booth_sel_row
    import booth_pkg::*;
(
    input  booth_sel_e          sel,
    input  logic [EXT_W-1:0]    ext_x,
    output logic [PROD_W-1:0]   row
);

    logic [PROD_W-1:0] x_wide;

    always_comb begin
        x_wide = {{(PROD_W - EXT_W){ext_x[EXT_W-1]}}, ext_x};
        case (sel)
            POS1:    row = x_wide;
            POS2:    row = x_wide << 1;
            NEG1:    row = ~x_wide + 1'b1;
            NEG2:    row = ~(x_wide << 1) + 1'b1;
            default: row = '0;
        endcase
    end

endmodule

// File: rtl/booth_pp_sender.sv
// Booth radix-4 partial-product sender: builds the row bank, exposes it as
// column vectors and holds it for the tree. BOOTH_PP_DUAL_EN decodes two rows per cycle.
//   state | meaning
//   IDLE  | waiting for start, operands latched on start
//   GEN   | writing rows, pp_idx is the next row to write
//   SEND  | swt_begin high, bank frozen until swt_end
//   DONE  | one-cycle done pulse
module booth_pp_sender
    import booth_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       is_signed,
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    output logic                       busy,
    output logic                       done,
    output logic                       swt_begin,
    input  logic                       swt_end,
    output logic [PROD_W*PP_NUM-1:0]   pp_col
);

`ifdef BOOTH_PP_DUAL_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               pp_idx_q, pp_idx_d;
    logic [WIDTH-1:0]               x_q, x_d, y_q, y_d;
    logic                           sgn_q, sgn_d;
    logic                           swt_begin_q, swt_begin_d;
    logic [PP_NUM-1:0][PROD_W-1:0]  rows_q, rows_d;

    logic [EXT_W-1:0]   ext_x, ext_y;
    logic [EXT_W+2:0]   grp;
    booth_sel_e         sel_a;
    logic [PROD_W-1:0]  row_raw_a, row_a;

    assign ext_x = sgn_q ? {{2{x_q[WIDTH-1]}}, x_q} : {2'b00, x_q};
    assign ext_y = sgn_q ? {{2{y_q[WIDTH-1]}}, y_q} : {2'b00, y_q};
    // Two zero pad bits keep the odd-row slice in range when pp_idx is the last row.
    assign grp   = {2'b00, ext_y, 1'b0};

    assign sel_a = booth_decode(grp[{pp_idx_q, 1'b0} +: 3]);

    booth_sel_row u_row_a (
        .sel   (sel_a),
        .ext_x (ext_x),
        .row   (row_raw_a)
    );

    assign row_a = row_raw_a << {pp_idx_q, 1'b0};

`ifdef BOOTH_PP_DUAL_EN
    logic [IDX_W-1:0]   pp_idx_b;
    booth_sel_e         sel_b;
    logic [PROD_W-1:0]  row_raw_b, row_b;

    assign pp_idx_b = pp_idx_q + 1'b1;
    assign sel_b    = booth_decode(grp[{pp_idx_b, 1'b0} +: 3]);

    booth_sel_row u_row_b (
        .sel   (sel_b),
        .ext_x (ext_x),
        .row   (row_raw_b)
    );

    assign row_b = row_raw_b << {pp_idx_b, 1'b0};
`endif

    always_comb begin
        state_d     = state_q;
        pp_idx_d    = pp_idx_q;
        x_d         = x_q;
        y_d         = y_q;
        sgn_d       = sgn_q;
        swt_begin_d = swt_begin_q;
        rows_d      = rows_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = GEN;
                    x_d      = x;
                    y_d      = y;
                    sgn_d    = is_signed;
                    pp_idx_d = '0;
                end
            end
            GEN: begin
                rows_d[pp_idx_q] = row_a;
`ifdef BOOTH_PP_DUAL_EN
                if (32'(pp_idx_b) < PP_NUM) begin
                    rows_d[pp_idx_b] = row_b;
                end
`endif
                if (32'(pp_idx_q) + STEP >= PP_NUM) begin
                    state_d     = SEND;
                    swt_begin_d = 1'b1;
                end else begin
                    pp_idx_d = pp_idx_q + IDX_W'(STEP);
                end
            end
            SEND: begin
                if (swt_end) begin
                    state_d     = DONE;
                    swt_begin_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pp_idx_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sgn_q       <= 1'b0;
            swt_begin_q <= 1'b0;
            rows_q      <= '0;
        end else begin
            state_q     <= state_d;
            pp_idx_q    <= pp_idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sgn_q       <= sgn_d;
            swt_begin_q <= swt_begin_d;
            rows_q      <= rows_d;
        end
    end

    for (genvar k = 0; k < PROD_W; k++) begin : g_col
        for (genvar i = 0; i < PP_NUM; i++) begin : g_bit
            assign pp_col[k*PP_NUM + i] = rows_q[i][k];
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign swt_begin = swt_begin_q;

endmodule

// File: doc/booth_pp_sender.md
Name: booth_pp_sender

Overview:
- Producer side of the sequential Wallace-tree interface: Booth radix-4 partial-product generator feeding the SubWTree column slices.
- Latches an operand pair, builds 17 aligned 64-bit partial-product rows, transposes them into per-column 17-bit vectors, then holds them under the swt_begin/swt_end handshake until the tree finishes.
- Sits between the multiplier front-end (operand issue) and the bank of column-compressor slices.

Parameters:
- WIDTH, 32, operand width; must be even.
- PP_NUM, WIDTH/2+1 (17), partial-product rows = column vector width.
- PROD_W, 2*WIDTH (64), product width = number of columns.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of transaction.
- swt_begin  out  1  tree start; held high until swt_end is seen.
- swt_end  in  1  end flag from tree slice 0.
- pp_col  out  PROD_W*PP_NUM  column k = pp_col[k*PP_NUM +: PP_NUM]; bit i of column k = bit k of row i.

Behaviour:
- Reset: state IDLE, busy=0, done=0, swt_begin=0, row bank and pp_col = 0, pp_idx=0. Reset mid-transaction aborts immediately, with no done pulse.
- States:
  - IDLE -> GEN on start; latch x, y and is_signed on that edge; pp_idx=0.
  - GEN: one Booth group per cycle, pp_idx 0..PP_NUM-1. After writing row PP_NUM-1, go to SEND and set swt_begin=1 on the same edge.
  - SEND: hold swt_begin=1 and pp_col stable. On swt_end=1, go to DONE, swt_begin=0.
  - DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored; operands are not re-latched.
- Operand extension: ext_x = 34-bit sign-extension of x if is_signed, else zero-extension. ext_y is built the same way. Grouping vector is {ext_y,1'b0}.
- Row i uses triple {ext_y[2i+1], ext_y[2i], ext_y[2i-1]}, with ext_y[-1]=0, Booth-decoded:
  - 000/111 -> 0
  - 001/010 -> +X
  - 011 -> +2X
  - 100 -> -2X
  - 101/110 -> -X
- Row value = the decoded multiple, true two's-complement negated (no separate neg bit), sign-extended to PROD_W, shifted left by 2i, truncated to PROD_W bits.
- Invariant: sum of all rows mod 2^PROD_W = product. For signed operands row 16 is always 0.
- pp_col is a wiring transpose of the registered row bank. It changes during GEN, which the tree ignores because swt_begin=0.
- Latency: start sampled at edge T. Rows written at edges T+1..T+17; swt_begin high from T+17. With the tree's swt_end at T+17+n, done is high for the cycle after that edge.
- swt_end while not in SEND is ignored. swt_end at the same edge swt_begin rises is ignored, because the edge is still in GEN.

Optional Feature:
- Macro: BOOTH_PP_DUAL_EN.
- Defined: GEN decodes two groups per cycle (rows 2j and 2j+1); the odd final row is written alone. GEN lasts 9 cycles and swt_begin rises at T+9.
- Undefined: one group per cycle as above. Row contents and the handshake are identical either way.

Decomposition:
- Shared package booth_pkg:
  - Booth triple-to-selection enum: ZERO, POS1, POS2, NEG1, NEG2.
  - PP_NUM and PROD_W constants.
  - State enum: IDLE, GEN, SEND, DONE.
- Sub-module booth_sel_row: combinational decode of one triple plus ext_x into one PROD_W row before shifting. Instantiated once, or twice under BOOTH_PP_DUAL_EN.

Test Plan:
- Unsigned x=3, y=5, swt_end pulsed 6 cycles after swt_begin: column-weighted sum of pp_col = 15; done pulses once; busy falls in the same cycle.
- Signed x=0xFFFFFFFF, y=0xFFFFFFFF: row sum mod 2^64 = 1; row 16 = 0.
- Signed x=y=0x80000000 -> 0x4000000000000000. Unsigned x=y=0xFFFFFFFF -> 0xFFFFFFFE00000001.
- Handshake: swt_end held low for 20 cycles in SEND, then high. Required: swt_begin stays high and pp_col is unchanged throughout; a start pulse during SEND is ignored; swt_begin drops on the swt_end edge.
- rst asserted at GEN pp_idx=8: next cycle IDLE, all outputs 0, no done. A subsequent start with x=7, y=9 gives row sum 63.
- BOOTH_PP_DUAL_EN build with the same vectors: identical row sums; swt_begin rises at start+9.
